// File: rtl/rv32_decode_queue_pkg.sv
// Shared types and opcode constants for the RV32I decode queue.
// Optional statistics counters are enabled with the DECODE_STATS_EN macro
// (see rv32_decode_queue.sv).
package rv32_decode_queue_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] HALT_INSTR = 32'h00010073;

    typedef enum logic [2:0] {
        UNIT_ALU = 3'd0,
        UNIT_BRU = 3'd1,
        UNIT_MAU = 3'd2
    } proc_unit_t;

    typedef enum logic [2:0] {
        TYPE_R = 3'd0,
        TYPE_I = 3'd1,
        TYPE_S = 3'd2,
        TYPE_B = 3'd3,
        TYPE_U = 3'd4,
        TYPE_J = 3'd5
    } op_type_t;

    typedef enum logic [1:0] {
        Q_RUN    = 2'd0,
        Q_DRAIN  = 2'd1,
        Q_HALTED = 2'd2
    } queue_state_t;

    // pc is carried at full 32 bits; the queue narrows it to PC_W on output.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        proc_unit_t  unit;
        op_type_t    op_type;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
        logic        halt;
    } decoded_instr_t;

    // Immediate as implied by the opcode alone; legality is judged elsewhere.
    function automatic logic [31:0] get_full_imm(input logic [31:0] instr);
        logic [31:0] imm;
        imm = '0;
        case (instr[6:0])
            OPC_OP_IMM: begin
                if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101)
                    imm = {27'b0, instr[24:20]};
                else
                    imm = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_LOAD, OPC_JALR: imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH: imm = {{19{instr[31]}}, instr[31], instr[7],
                               instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm = {instr[31:12], 12'b0};
            OPC_JAL:    imm = {{11{instr[31]}}, instr[31], instr[19:12],
                               instr[20], instr[30:21], 1'b0};
            default:    imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv32_decode_comb.sv
// Purely combinational RV32I decoder: raw word + PC -> decoded_instr_t.
// Illegal words decode to ALU/R with zero fields; HALT decodes to BRU with
// zero fields.
module rv32_decode_comb
    import rv32_decode_queue_pkg::*;
(
    input  logic [31:0]    instr,
    input  logic [31:0]    pc,
    output decoded_instr_t dec
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    logic       halt;
    proc_unit_t unit;
    op_type_t   op_type;
    logic       use_rd;
    logic       use_rs1;
    logic       use_rs2;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign halt   = (instr == HALT_INSTR);

    // Classify the opcode and decide which register fields are meaningful.
    always_comb begin
        legal   = 1'b0;
        unit    = UNIT_ALU;
        op_type = TYPE_R;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                legal = 1'b1; op_type = TYPE_U; use_rd = 1'b1;
            end
            OPC_JAL: begin
                legal = 1'b1; unit = UNIT_BRU; op_type = TYPE_J; use_rd = 1'b1;
            end
            OPC_JALR: begin
                legal = (f3 == 3'b000); unit = UNIT_BRU; op_type = TYPE_I;
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                legal = (f3 != 3'b010) && (f3 != 3'b011);
                unit = UNIT_BRU; op_type = TYPE_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                unit = UNIT_MAU; op_type = TYPE_I; use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OPC_STORE: begin
                legal = f3 inside {3'b000, 3'b001, 3'b010};
                unit = UNIT_MAU; op_type = TYPE_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                if (f3 == 3'b001)      legal = (f7 == 7'h00);
                else if (f3 == 3'b101) legal = (f7 == 7'h00) || (f7 == 7'h20);
                else                   legal = 1'b1;
                op_type = TYPE_I; use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OPC_OP: begin
                legal = (f7 == 7'h00) ||
                        ((f7 == 7'h20) && (f3 == 3'b000 || f3 == 3'b101));
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Assemble the entry; HALT and illegal words carry no operand fields.
    always_comb begin
        dec       = '0;
        dec.pc    = pc;
        dec.instr = instr;
        if (halt) begin
            dec.halt = 1'b1;
            dec.unit = UNIT_BRU;
        end else if (legal) begin
            dec.unit    = unit;
            dec.op_type = op_type;
            dec.rd      = use_rd  ? instr[11:7]  : 5'd0;
            dec.rs1     = use_rs1 ? instr[19:15] : 5'd0;
            dec.rs2     = use_rs2 ? instr[24:20] : 5'd0;
            dec.imm     = get_full_imm(instr);
        end else begin
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/rv32_decode_queue.sv
// Buffered RV32I decode queue: decodes at enqueue, holds DEPTH entries and
// runs a RUN -> DRAIN -> HALTED stop machine on HALT.
// Define DECODE_STATS_EN to add saturating per-category dequeue counters.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. valid never depends on ready; in_ready does not look at
// out_ready, and head fields are stable while out_valid && !out_ready.
module rv32_decode_queue
    import rv32_decode_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int STAT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output logic [2:0]                 out_unit,
    output logic [2:0]                 out_type,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [31:0]                out_imm,
    output logic                       out_illegal,
    output logic                       out_halt,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] count,
`ifdef DECODE_STATS_EN
    output logic [STAT_W-1:0]          stat_alu,
    output logic [STAT_W-1:0]          stat_bru,
    output logic [STAT_W-1:0]          stat_mau,
    output logic [STAT_W-1:0]          stat_illegal,
`endif
    output logic [1:0]                 state_dbg
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    decoded_instr_t     mem [DEPTH];
    decoded_instr_t     in_dec;
    decoded_instr_t     head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    queue_state_t       state;
    logic               push;
    logic               pop;

    rv32_decode_comb u_decode (
        .instr (in_instr),
        .pc    (32'(in_pc)),
        .dec   (in_dec)
    );

    assign in_ready  = (count_q < DEPTH_C) && (state == Q_RUN);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Empty queue presents all-zero fields.
    assign head = out_valid ? mem[rd_ptr] : '0;

    assign out_pc      = head.pc[PC_W-1:0];
    assign out_instr   = head.instr;
    assign out_unit    = head.unit;
    assign out_type    = head.op_type;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_imm     = head.imm;
    assign out_illegal = head.illegal;
    assign out_halt    = head.halt;
    assign halted      = (state == Q_HALTED);
    assign count       = count_q;
    assign state_dbg   = state;

    // Entry storage; written only on an accepted push outside flush.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= in_dec;
    end

    // Pointers, occupancy and the halt state machine; flush wins over all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            state   <= Q_RUN;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            state   <= Q_RUN;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
            case (state)
                Q_RUN:    if (push && in_dec.halt) state <= Q_DRAIN;
                Q_DRAIN:  if (pop && head.halt)    state <= Q_HALTED;
                Q_HALTED: state <= Q_HALTED;
                default:  state <= Q_RUN;
            endcase
        end
    end

`ifdef DECODE_STATS_EN
    // Saturating dequeue counters; illegal entries count only as illegal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_alu     <= '0;
            stat_bru     <= '0;
            stat_mau     <= '0;
            stat_illegal <= '0;
        end else if (pop && !flush) begin
            if (head.illegal) begin
                if (stat_illegal != '1) stat_illegal <= stat_illegal + 1'b1;
            end else begin
                case (head.unit)
                    UNIT_BRU: if (stat_bru != '1) stat_bru <= stat_bru + 1'b1;
                    UNIT_MAU: if (stat_mau != '1) stat_mau <= stat_mau + 1'b1;
                    default:  if (stat_alu != '1) stat_alu <= stat_alu + 1'b1;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv32_decode_queue.sv
// Testbench for rv32_decode_queue: directed scenarios followed by random
// traffic, compared against a queue-based reference model.
module tb_rv32_decode_queue;
    import rv32_decode_queue_pkg::*;

    localparam int DEPTH  = 4;
    localparam int PC_W   = 32;
    localparam int STAT_W = 16;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [31:0]       out_instr;
    logic [2:0]        out_unit;
    logic [2:0]        out_type;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [31:0]       out_imm;
    logic              out_illegal;
    logic              out_halt;
    logic              halted;
    logic [2:0]        count;
    logic [1:0]        state_dbg;
`ifdef DECODE_STATS_EN
    logic [STAT_W-1:0] stat_alu;
    logic [STAT_W-1:0] stat_bru;
    logic [STAT_W-1:0] stat_mau;
    logic [STAT_W-1:0] stat_illegal;
`endif

    rv32_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .STAT_W(STAT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_unit    (out_unit),
        .out_type    (out_type),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_illegal (out_illegal),
        .out_halt    (out_halt),
        .halted      (halted),
        .count       (count),
`ifdef DECODE_STATS_EN
        .stat_alu    (stat_alu),
        .stat_bru    (stat_bru),
        .stat_mau    (stat_mau),
        .stat_illegal(stat_illegal),
`endif
        .state_dbg   (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: scoreboard queue of {pc, instr}, run state, stats.
    logic [63:0]       exp_q[$];
    int                m_state;   // 0 running, 1 draining, 2 halted
    logic [STAT_W-1:0] m_alu, m_bru, m_mau, m_ill;

    typedef struct {
        proc_unit_t  unit;
        op_type_t    otype;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        bit          illegal;
        bit          halt;
    } ref_t;

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] s;
        s = 32'd1 << (bits - 1);
        return (v ^ s) - s;
    endfunction

    function automatic ref_t ref_decode(input logic [31:0] w);
        ref_t r;
        bit   ok;
        int   f3, f7;
        r.unit = UNIT_ALU; r.otype = TYPE_R;
        r.rd = 0; r.rs1 = 0; r.rs2 = 0; r.imm = 0; r.illegal = 0; r.halt = 0;
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        if (w == 32'h00010073) begin
            r.unit = UNIT_BRU; r.halt = 1;
            return r;
        end
        ok = 1;
        case (w[6:0])
            7'h37, 7'h17: begin
                r.otype = TYPE_U; r.rd = w[11:7]; r.imm = w & 32'hFFFFF000;
            end
            7'h6F: begin
                r.unit = UNIT_BRU; r.otype = TYPE_J; r.rd = w[11:7];
                r.imm = sext({w[31], w[19:12], w[20], w[30:21], 1'b0}, 21);
            end
            7'h67: begin
                ok = (f3 == 0);
                r.unit = UNIT_BRU; r.otype = TYPE_I; r.rd = w[11:7]; r.rs1 = w[19:15];
                r.imm = sext(w[31:20], 12);
            end
            7'h63: begin
                ok = (f3 != 2) && (f3 != 3);
                r.unit = UNIT_BRU; r.otype = TYPE_B; r.rs1 = w[19:15]; r.rs2 = w[24:20];
                r.imm = sext({w[31], w[7], w[30:25], w[11:8], 1'b0}, 13);
            end
            7'h03: begin
                ok = (f3 <= 2) || (f3 == 4) || (f3 == 5);
                r.unit = UNIT_MAU; r.otype = TYPE_I; r.rd = w[11:7]; r.rs1 = w[19:15];
                r.imm = sext(w[31:20], 12);
            end
            7'h23: begin
                ok = (f3 <= 2);
                r.unit = UNIT_MAU; r.otype = TYPE_S; r.rs1 = w[19:15]; r.rs2 = w[24:20];
                r.imm = sext({w[31:25], w[11:7]}, 12);
            end
            7'h13: begin
                if (f3 == 1)      ok = (f7 == 0);
                else if (f3 == 5) ok = (f7 == 0) || (f7 == 32);
                r.otype = TYPE_I; r.rd = w[11:7]; r.rs1 = w[19:15];
                r.imm = (f3 == 1 || f3 == 5) ? 32'(w[24:20]) : sext(w[31:20], 12);
            end
            7'h33: begin
                ok = (f7 == 0) || ((f7 == 32) && (f3 == 0 || f3 == 5));
                r.rd = w[11:7]; r.rs1 = w[19:15]; r.rs2 = w[24:20];
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            r.unit = UNIT_ALU; r.otype = TYPE_R;
            r.rd = 0; r.rs1 = 0; r.rs2 = 0; r.imm = 0; r.illegal = 1;
        end
        return r;
    endfunction

    task automatic check_outputs();
        ref_t r;
        int   n;
        n = exp_q.size();
        chk("out_valid", 32'(out_valid), 32'(n > 0));
        chk("count", 32'(count), 32'(n));
        chk("in_ready", 32'(in_ready), 32'(n < DEPTH && m_state == 0));
        chk("halted", 32'(halted), 32'(m_state == 2));
        if (n > 0) begin
            r = ref_decode(exp_q[0][31:0]);
            chk("out_pc", 32'(out_pc), exp_q[0][63:32]);
            chk("out_instr", out_instr, exp_q[0][31:0]);
            chk("out_unit", 32'(out_unit), 32'(r.unit));
            chk("out_type", 32'(out_type), 32'(r.otype));
            chk("out_regs", {17'b0, out_rd, out_rs1, out_rs2}, {17'b0, r.rd, r.rs1, r.rs2});
            chk("out_imm", out_imm, r.imm);
            chk("out_flags", {30'b0, out_illegal, out_halt}, {30'b0, r.illegal, r.halt});
        end else begin
            chk("idle_imm", out_imm, 32'd0);
            chk("idle_regs", {17'b0, out_rd, out_rs1, out_rs2}, 32'd0);
            chk("idle_misc", {24'b0, out_unit, out_type, out_illegal, out_halt}, 32'd0);
        end
`ifdef DECODE_STATS_EN
        chk("stat_alu", 32'(stat_alu), 32'(m_alu));
        chk("stat_bru", 32'(stat_bru), 32'(m_bru));
        chk("stat_mau", 32'(stat_mau), 32'(m_mau));
        chk("stat_illegal", 32'(stat_illegal), 32'(m_ill));
`endif
    endtask

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Driver: called at a falling edge; drives, checks, advances the model
    // across the rising edge and returns at the next falling edge.
    task automatic cycle(input bit v, input logic [31:0] w, input logic [31:0] pc,
                         input bit ordy, input bit fl);
        bit          m_push, m_pop;
        logic [63:0] e;
        ref_t        r;
        in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
        check_outputs();
        m_push = v && (exp_q.size() < DEPTH) && (m_state == 0);
        m_pop  = (exp_q.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            m_state = 0;
        end else begin
            if (m_pop) begin
                e = exp_q.pop_front();
                r = ref_decode(e[31:0]);
                if (r.illegal)               m_ill = sat_inc(m_ill);
                else if (r.unit == UNIT_BRU) m_bru = sat_inc(m_bru);
                else if (r.unit == UNIT_MAU) m_mau = sat_inc(m_mau);
                else                         m_alu = sat_inc(m_alu);
                if (r.halt && m_state == 1) m_state = 2;
            end
            if (m_push) begin
                exp_q.push_back({pc, w});
                if (w == 32'h00010073) m_state = 1;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0: w[6:0] = 7'h37;
            1: w[6:0] = 7'h17;
            2: w[6:0] = 7'h6F;
            3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h63;
            5: w[6:0] = 7'h03;
            6: w[6:0] = 7'h23;
            7, 8: begin
                w[6:0] = (k == 7) ? 7'h13 : 7'h33;
                if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            9:  if ($urandom_range(0, 1) == 1) w = 32'h00010073;
            10: w = 32'h0;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        exp_q.delete(); m_state = 0;
        m_alu = 0; m_bru = 0; m_mau = 0; m_ill = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADDI x1,x0,-1 into an empty queue
        cycle(1, 32'hFFF00093, 32'h1000, 1, 0);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_unit", 32'(out_unit), 32'(UNIT_ALU));
        chk("addi_type", 32'(out_type), 32'(TYPE_I));
        chk("addi_rd", 32'(out_rd), 32'd1);
        chk("addi_rs1", 32'(out_rs1), 32'd0);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        cycle(0, 0, 0, 1, 0);

        // BEQ then LUI
        cycle(1, 32'hFE000EE3, 32'h1004, 0, 0);
        cycle(1, 32'h123452B7, 32'h1008, 0, 0);
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        chk("beq_unit", 32'(out_unit), 32'(UNIT_BRU));
        chk("beq_type", 32'(out_type), 32'(TYPE_B));
        cycle(0, 0, 0, 1, 0);
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_rd", 32'(out_rd), 32'd5);
        chk("lui_type", 32'(out_type), 32'(TYPE_U));
        cycle(0, 0, 0, 1, 0);

        // Fill to DEPTH with a fifth word offered
        for (int i = 0; i < 5; i++) cycle(1, 32'h00108093 + (i << 20), 32'h2000 + 4 * i, 0, 0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
        chk("drained_count", 32'(count), 32'd0);

        // HALT blocks further input, then flush recovers
        cycle(1, 32'h00010073, 32'h3000, 0, 0);
        for (int i = 0; i < 2; i++) cycle(1, 32'hFFF00093, 32'h3004, 0, 0);
        chk("drain_in_ready", 32'(in_ready), 32'd0);
        chk("drain_count", 32'(count), 32'd1);
        cycle(1, 32'hFFF00093, 32'h3004, 1, 0);
        chk("halted_set", 32'(halted), 32'd1);
        chk("halted_in_ready", 32'(in_ready), 32'd0);
        cycle(1, 32'hFFF00093, 32'h3004, 0, 1);
        chk("flush_halted", 32'(halted), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        cycle(1, 32'hFFF00093, 32'h3004, 0, 0);
        chk("post_flush_count", 32'(count), 32'd1);
        cycle(0, 0, 0, 1, 0);

        // All-zero word is illegal
        cycle(1, 32'h0, 32'h4000, 0, 0);
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_fields", {17'b0, out_rd, out_rs1, out_rs2}, 32'd0);
        chk("ill_imm", out_imm, 32'd0);
        cycle(0, 0, 0, 1, 0);
`ifdef DECODE_STATS_EN
        chk("ill_stat", 32'(stat_illegal), 32'd1);
`endif

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) cycle(1, 32'h00208113, 32'h5000 + 4 * i, 0, 0);
        in_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete(); m_state = 0;
        m_alu = 0; m_bru = 0; m_mau = 0; m_ill = 0;
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit v, ordy, fl;
            v    = ($urandom_range(0, 99) < 70);
            ordy = ($urandom_range(0, 99) < 60);
            fl   = (m_state == 2) ? ($urandom_range(0, 99) < 20) : ($urandom_range(0, 99) < 2);
            cycle(v, gen_instr(), $urandom & 32'hFFFFFFFC, ordy, fl);
        end
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv32_decode_queue.md
Name: rv32_decode_queue

Overview:
- Buffered RV32I front-end decoder between instruction fetch and the ALU/BRU/MAU dispatch logic.
- Accepts raw instruction words with their PC over a valid/ready handshake and decodes them.
- Stores decoded entries in a DEPTH-entry FIFO and presents them in order over a second valid/ready handshake.
- Adds full sign-extended immediate reconstruction, illegal-opcode flagging and a HALT drain/stop state machine.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- PC_W, 32, PC width carried with each entry.
- STAT_W, 16, width of statistics counters (only under DECODE_STATS_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  drop all entries and return to RUN.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue accepts; transfer occurs when in_valid and in_ready are both high.
- in_instr  in  32  raw instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_pc  out  PC_W  PC of head entry.
- out_instr  out  32  raw word of head entry.
- out_unit  out  3  proc_unit_t: ALU, BRU or MAU.
- out_type  out  3  op_type_t: R, I, S, B, U or J.
- out_rd, out_rs1, out_rs2  out  5 each  register fields; 0 where the format has none.
- out_imm  out  32  sign-extended immediate.
- out_illegal  out  1  no opcode mask matched.
- out_halt  out  1  head entry is HALT (32'h00010073).
- halted  out  1  HALTED state.
- count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (async, rst_n low): FIFO empty, state RUN. All outputs 0 except in_ready=1.
- Decode is combinational on in_instr and registered at enqueue.
- Latency: an accept into an empty queue gives out_valid=1 on the next cycle. There is no same-cycle bypass.
- in_ready = (count < DEPTH) && state==RUN. It does not depend on out_ready, so there is no push-through when full.
- Push and pop may occur in the same cycle: count is unchanged and order is preserved.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Immediates:
  - I-type: sign-extend [31:20].
  - Shift-immediates (SLLI/SRLI/SRAI): zero-extend [24:20].
  - S-type: sign-extend {[31:25],[11:7]}.
  - B-type: sign-extend {[31],[7],[30:25],[11:8],0}.
  - U-type: {[31:12],12'b0}.
  - J-type: sign-extend {[31],[19:12],[20],[30:21],0}.
  - R-type: 0.
- Unit mapping:
  - ALU: all register-register and immediate arithmetic, LUI, AUIPC.
  - BRU: JAL, JALR, all branches.
  - MAU: all loads and stores.
- Illegal: out_illegal=1, unit=ALU, type=R, rd/rs1/rs2=0, imm=0.
- HALT is legal: out_halt=1, unit=BRU, all fields 0.
- State machine:
  - RUN: accepting. An accepted HALT moves to DRAIN.
  - DRAIN: in_ready=0. Entries behind HALT drain normally. Dequeue of the HALT entry moves to HALTED.
  - HALTED: halted=1, in_ready=0, queue empty.
- flush: highest priority. The FIFO empties and state becomes RUN on the next edge. A same-cycle push or pop is discarded and not counted.
- A second HALT cannot be accepted in DRAIN.
- out_* fields hold their value while out_valid && !out_ready.
- When out_valid=0, out_* decoded fields are 0.

Optional Feature:
DECODE_STATS_EN
- Defined:
  - Adds outputs stat_alu, stat_bru, stat_mau, stat_illegal (STAT_W each).
  - Each counts dequeues of its category and saturates at all-ones.
  - Counters clear on rst_n only, not on flush. HALT counts as bru.
- Undefined: the ports and counters are absent.

Decomposition:
- Add to package opcodes:
  - a packed decoded_instr_t struct (pc, instr, unit, type, rd, rs1, rs2, imm, illegal, halt);
  - a queue_state_t enum {Q_RUN, Q_DRAIN, Q_HALTED};
  - a get_full_imm function returning the 32-bit sign-extended immediate.
- One sub-module, rv32_decode_comb: purely combinational instruction to decoded_instr_t. rv32_decode_queue holds the FIFO, state machine and counters.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093) into empty queue, out_ready=1 -> out_valid next cycle; unit=ALU, type=I, rd=1, rs1=0, imm=0xFFFFFFFF.
- BEQ x0,x0,-4 (0xFE000EE3) then LUI x5,0x12345 (0x123452B7) -> imm 0xFFFFFFFC, unit BRU, type B; then imm 0x12345000, rd=5, type U.
- DEPTH=4, out_ready=0, push 5 words -> in_ready drops after the 4th accept, count=4. Release out_ready -> all 4 delivered in order, count returns to 0.
- Push HALT then ADDI with in_valid held -> ADDI not accepted. halted=1 the cycle after HALT dequeues. flush -> halted=0, in_ready=1, ADDI accepted.
- 0x00000000 -> out_illegal=1, rd/rs1/rs2=0, imm=0. With DECODE_STATS_EN, stat_illegal=1 after dequeue.
- 3 entries queued, rst_n pulsed low mid-cycle -> out_valid=0 and count=0 immediately (asynchronous); in_ready=1.
